// File: rtl/sva_mon_pkg.sv
// Shared types and constants for the two-signal property monitor.
//   mode_e    : property select driven on the monitor's mode port
//   DELAY_MAX : largest consequent delay supported by the implication tracker
package sva_mon_pkg;

    typedef enum logic [1:0] {
        MODE_AND  = 2'd0,   // a & b
        MODE_OR   = 2'd1,   // a | b
        MODE_XNOR = 2'd2,   // !(a ^ b)
        MODE_IMPL = 2'd3    // a |-> ##DELAY b
    } mode_e;

    localparam int DELAY_MAX = 15;

endpackage

// File: rtl/sva_impl_tracker.sv
// Pending-attempt shift register for the implication property a |-> ##DELAY b.
// One bit per in-flight attempt; an attempt pushed at edge k sits in
// pending_q[DELAY-1] during the cycle before edge k+DELAY and resolves on the
// b value sampled at that edge.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears all attempts)
//   push           : start a new attempt at this edge (antecedent true)
//   flush          : discard every pending attempt at this edge, no report
//   b              : consequent signal sampled at this edge
//   resolve_valid  : an attempt resolves at this edge (combinational)
//   resolve_pass   : resolution result, valid with resolve_valid
module sva_impl_tracker
    import sva_mon_pkg::*;
#(
    parameter int DELAY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic flush,
    input  logic b,
    output logic resolve_valid,
    output logic resolve_pass
);

    if (DELAY < 1 || DELAY > DELAY_MAX) begin : g_bad_delay
        $error("sva_impl_tracker: DELAY out of range 1..15");
    end

    logic [DELAY-1:0] pending_q;
    logic [DELAY-1:0] pending_d;

    always_comb begin
        pending_d    = '0;
        // A push on a flushing edge belongs to the new mode, so it survives.
        pending_d[0] = push;
        for (int i = 1; i < DELAY; i++) begin
            pending_d[i] = pending_q[i-1] & ~flush;
        end
        resolve_valid = pending_q[DELAY-1] & ~flush;
        resolve_pass  = b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/sva_prop_monitor.sv
// Hardware evaluator for a fixed set of two-signal concurrent properties,
// matching simulator assert property (@(posedge clk) ...) timing edge for edge.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : start an attempt at this edge
//   mode       : property select (mode_e)
//   a, b       : observed signals
//   pass_o     : one-cycle pulse, non-vacuous pass
//   fail_o     : one-cycle pulse, failure
//   vacuous_o  : one-cycle pulse, implication antecedent false
//   fail_ts    : start cycle of the most recent failing attempt
//   pass_cnt   : saturating pass counter
//   fail_cnt   : saturating fail counter
//   cycle_cnt  : free-running edge counter, first edge after reset is cycle 0
// All outputs are registered; the value registered at edge k reflects the
// inputs held just before edge k.
module sva_prop_monitor
    import sva_mon_pkg::*;
#(
    parameter int DELAY = 2,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_e            mode,
    input  logic             a,
    input  logic             b,
    output logic             pass_o,
    output logic             fail_o,
    output logic             vacuous_o,
    output logic [TS_W-1:0]  fail_ts,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [TS_W-1:0]  cycle_cnt
);

    localparam logic [TS_W-1:0] DELAY_TS = TS_W'(DELAY);

    mode_e            prev_mode_q, prev_mode_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             vacuous_q, vacuous_d;
    logic [TS_W-1:0]  fail_ts_q, fail_ts_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [TS_W-1:0]  cycle_cnt_q, cycle_cnt_d;

    logic flush;
    logic push;
    logic resolve_valid;
    logic resolve_pass;
    logic expr;
    logic comb_eval;
    logic comb_fail;
    logic impl_fail;

    sva_impl_tracker #(
        .DELAY (DELAY)
    ) u_tracker (
        .clk           (clk),
        .rst           (rst),
        .push          (push),
        .flush         (flush),
        .b             (b),
        .resolve_valid (resolve_valid),
        .resolve_pass  (resolve_pass)
    );

    always_comb begin
        // Any mode change abandons in-flight implication attempts silently.
        flush = (mode != prev_mode_q);
        push  = en & (mode == MODE_IMPL) & a;

        expr = 1'b0;
        case (mode)
            MODE_AND:  expr = a & b;
            MODE_OR:   expr = a | b;
            MODE_XNOR: expr = ~(a ^ b);
            default:   expr = 1'b0;
        endcase

        comb_eval = en & (mode != MODE_IMPL);
        comb_fail = comb_eval & ~expr;
        impl_fail = resolve_valid & ~resolve_pass;

        // Resolution only happens while in implication mode (pending is
        // empty otherwise), so comb and impl results never coincide.
        pass_d    = (comb_eval & expr) | (resolve_valid & resolve_pass);
        fail_d    = comb_fail | impl_fail;
        vacuous_d = en & (mode == MODE_IMPL) & ~a;

        fail_ts_d = fail_ts_q;
        if (comb_fail) begin
            fail_ts_d = cycle_cnt_q;
        end else if (impl_fail) begin
            // Report the antecedent edge; wraps like cycle_cnt.
            fail_ts_d = cycle_cnt_q - DELAY_TS;
        end

        pass_cnt_d = pass_cnt_q;
        if (pass_d && (pass_cnt_q != '1)) begin
            pass_cnt_d = pass_cnt_q + CNT_W'(1);
        end

        fail_cnt_d = fail_cnt_q;
        if (fail_d && (fail_cnt_q != '1)) begin
            fail_cnt_d = fail_cnt_q + CNT_W'(1);
        end

        cycle_cnt_d = cycle_cnt_q + TS_W'(1);
        prev_mode_d = mode;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_mode_q <= MODE_AND;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            vacuous_q   <= 1'b0;
            fail_ts_q   <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            prev_mode_q <= prev_mode_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            vacuous_q   <= vacuous_d;
            fail_ts_q   <= fail_ts_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
        end
    end

    assign pass_o    = pass_q;
    assign fail_o    = fail_q;
    assign vacuous_o = vacuous_q;
    assign fail_ts   = fail_ts_q;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_sva_prop_monitor.sv
// Bench for sva_prop_monitor. Main instance: DELAY=2, default widths.
// Second instance with CNT_W=2, TS_W=4 exercises saturation and wrap.
// Pulse expectations {pass,fail,vacuous} are queued at each edge and popped
// by an independent monitor on the following falling edge.
module tb_sva_prop_monitor;
    import sva_mon_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    mode_e       mode;
    logic        a;
    logic        b;
    logic        pass_o;
    logic        fail_o;
    logic        vacuous_o;
    logic [31:0] fail_ts;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [31:0] cycle_cnt;

    logic        s_rst;
    logic        s_en;
    mode_e       s_mode;
    logic        s_a;
    logic        s_b;
    logic        s_pass_o;
    logic        s_fail_o;
    logic        s_vacuous_o;
    logic [3:0]  s_fail_ts;
    logic [1:0]  s_pass_cnt;
    logic [1:0]  s_fail_cnt;
    logic [3:0]  s_cycle_cnt;

    int total = 0;
    int bad   = 0;
    logic [2:0] exp_q[$];

    sva_prop_monitor #(.DELAY(2), .CNT_W(16), .TS_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .pass_o    (pass_o),
        .fail_o    (fail_o),
        .vacuous_o (vacuous_o),
        .fail_ts   (fail_ts),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .cycle_cnt (cycle_cnt)
    );

    sva_prop_monitor #(.DELAY(2), .CNT_W(2), .TS_W(4)) dut_s (
        .clk       (clk),
        .rst       (s_rst),
        .en        (s_en),
        .mode      (s_mode),
        .a         (s_a),
        .b         (s_b),
        .pass_o    (s_pass_o),
        .fail_o    (s_fail_o),
        .vacuous_o (s_vacuous_o),
        .fail_ts   (s_fail_ts),
        .pass_cnt  (s_pass_cnt),
        .fail_cnt  (s_fail_cnt),
        .cycle_cnt (s_cycle_cnt)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, got t=%0t required completion", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [2:0] exp_v;
        logic [2:0] act_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pass_o, fail_o, vacuous_o};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL pulses @%0t: got pass/fail/vac=%b required %b", $time, act_v, exp_v);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Drive inputs (just after an edge), then queue the pulses expected after
    // the next edge once that edge has happened.
    task automatic step(input logic r, input logic e, input mode_e m,
                        input logic ai, input logic bi, input logic [2:0] x);
        rst  = r;
        en   = e;
        mode = m;
        a    = ai;
        b    = bi;
        @(posedge clk);
        exp_q.push_back(x);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic s_edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b0; mode = MODE_AND; a = 1'b0; b = 1'b0;
        s_rst = 1'b1; s_en = 1'b0; s_mode = MODE_AND; s_a = 1'b0; s_b = 1'b0;

        step(1, 0, MODE_AND, 0, 0, 3'b000);
        step(1, 0, MODE_AND, 0, 0, 3'b000);
        check("reset_pass_cnt",  32'(pass_cnt),  0);
        check("reset_fail_cnt",  32'(fail_cnt),  0);
        check("reset_cycle_cnt", cycle_cnt,      0);

        // MODE_AND, edges 0..3: 00 01 11 10
        step(0, 1, MODE_AND, 0, 0, 3'b010);
        step(0, 1, MODE_AND, 0, 1, 3'b010);
        step(0, 1, MODE_AND, 1, 1, 3'b100);
        step(0, 1, MODE_AND, 1, 0, 3'b010);
        check("and_fail_cnt", 32'(fail_cnt), 3);
        check("and_pass_cnt", 32'(pass_cnt), 1);
        check("and_fail_ts",  fail_ts,       3);

        // MODE_OR, edges 4..7
        step(0, 1, MODE_OR, 0, 0, 3'b010);
        step(0, 1, MODE_OR, 0, 1, 3'b100);
        step(0, 1, MODE_OR, 1, 1, 3'b100);
        step(0, 1, MODE_OR, 1, 0, 3'b100);
        check("or_fail_ts",  fail_ts,       4);
        check("or_pass_cnt", 32'(pass_cnt), 4);

        // MODE_XNOR, edges 8..11
        step(0, 1, MODE_XNOR, 0, 0, 3'b100);
        step(0, 1, MODE_XNOR, 0, 1, 3'b010);
        step(0, 1, MODE_XNOR, 1, 1, 3'b100);
        step(0, 1, MODE_XNOR, 1, 0, 3'b010);
        check("xnor_fail_ts",  fail_ts,       11);
        check("xnor_fail_cnt", 32'(fail_cnt), 6);

        // MODE_IMPL: attempts start at 13 (b=1 at 15) and 14 (b=0 at 16)
        step(0, 1, MODE_IMPL, 0, 0, 3'b001);   // edge 12
        step(0, 1, MODE_IMPL, 1, 0, 3'b000);   // edge 13
        step(0, 1, MODE_IMPL, 1, 0, 3'b000);   // edge 14
        step(0, 1, MODE_IMPL, 0, 1, 3'b101);   // edge 15: pass + vacuous
        step(0, 1, MODE_IMPL, 0, 0, 3'b011);   // edge 16: fail + vacuous
        check("impl_fail_ts",  fail_ts,       14);
        check("impl_fail_cnt", 32'(fail_cnt), 7);
        check("impl_pass_cnt", 32'(pass_cnt), 7);
        step(0, 1, MODE_IMPL, 0, 0, 3'b001);   // edge 17

        // Flush: attempt at 18 dropped by switching to AND at 19
        step(0, 1, MODE_IMPL, 1, 1, 3'b000);   // edge 18
        step(0, 1, MODE_AND,  0, 0, 3'b010);   // edge 19
        check("flush_fail_ts", fail_ts,   19);
        check("pre_en0_cycle", cycle_cnt, 20);
        // en=0 for 4 edges; edge 20 is where the flushed attempt would resolve
        step(0, 0, MODE_AND, 1, 0, 3'b000);    // edge 20
        step(0, 0, MODE_AND, 1, 1, 3'b000);
        step(0, 0, MODE_AND, 0, 0, 3'b000);
        step(0, 0, MODE_AND, 0, 1, 3'b000);    // edge 23
        check("en0_cycle_adv", cycle_cnt, 24);
        check("en0_fail_cnt",  32'(fail_cnt), 8);

        // In-flight attempt still resolves with en=0
        step(0, 1, MODE_IMPL, 1, 0, 3'b000);   // edge 24
        step(0, 0, MODE_IMPL, 0, 0, 3'b000);   // edge 25
        step(0, 0, MODE_IMPL, 0, 1, 3'b100);   // edge 26
        check("inflight_pass_cnt", 32'(pass_cnt), 8);

        // Reset with a pending attempt
        step(0, 1, MODE_IMPL, 1, 0, 3'b000);   // edge 27
        step(1, 1, MODE_IMPL, 0, 0, 3'b000);   // reset edge
        check("rst_mid_pass_cnt",  32'(pass_cnt), 0);
        check("rst_mid_fail_cnt",  32'(fail_cnt), 0);
        check("rst_mid_fail_ts",   fail_ts,       0);
        check("rst_mid_cycle_cnt", cycle_cnt,     0);
        step(0, 0, MODE_AND, 0, 0, 3'b000);    // cycle 0: no late result
        check("post_rst_cycle", cycle_cnt, 1);
        step(0, 1, MODE_AND, 0, 1, 3'b010);    // cycle 1
        check("post_rst_fail_ts",  fail_ts,       1);
        check("post_rst_fail_cnt", 32'(fail_cnt), 1);

        // Saturation and wrap on the narrow instance
        s_edges(1);
        s_rst = 1'b0; s_en = 1'b1; s_mode = MODE_AND; s_a = 1'b0; s_b = 1'b1;
        s_edges(3);
        check("sat_fail_cnt_3", 32'(s_fail_cnt), 3);
        s_edges(3);
        check("sat_fail_cnt_hold", 32'(s_fail_cnt),  3);
        check("sat_fail_ts",       32'(s_fail_ts),   5);
        check("sat_cycle_6",       32'(s_cycle_cnt), 6);
        s_en = 1'b0;
        s_edges(14);
        check("wrap_cycle_cnt", 32'(s_cycle_cnt), 4);
        check("wrap_pass_cnt",  32'(s_pass_cnt),  0);

        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sva_prop_monitor.md
# sva_prop_monitor

Synthesizable, cycle-accurate evaluator for a fixed set of two-signal concurrent properties on `a` and `b`. It mirrors simulator `assert property (@(posedge clk) ...)` semantics in hardware. Each clock edge samples the values `a` and `b` held just before that edge, starts an attempt, and reports pass, fail or vacuous success with a start timestamp. It sits beside the stimulus generator in the assertion tutorial benches, so simulator assertion messages and hardware results can be compared edge for edge, and it can be instantiated on FPGA where SVA is unavailable.

## Interface
- `DELAY`, default 2: consequent delay N for the implication mode; legal range 1..15.
- `CNT_W`, default 16: width of the pass and fail counters.
- `TS_W`, default 32: width of the cycle counter and the timestamp.

Ports:
- `clk`  in  1  clock; all evaluation on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  when 1, an attempt starts at this edge.
- `mode`  in  2  property select (`sva_mon_pkg::mode_e`).
- `a`  in  1  first observed signal.
- `b`  in  1  second observed signal.
- `pass_o`  out  1  one-cycle pulse: an attempt passed non-vacuously.
- `fail_o`  out  1  one-cycle pulse: an attempt failed.
- `vacuous_o`  out  1  one-cycle pulse: implication antecedent was false.
- `fail_ts`  out  TS_W  start cycle of the most recent failing attempt.
- `pass_cnt`  out  CNT_W  count of non-vacuous passes; saturating.
- `fail_cnt`  out  CNT_W  count of failures; saturating.
- `cycle_cnt`  out  TS_W  free-running edge counter; wraps.

## Operation
Modes:
- `MODE_AND` (0): `a & b`.
- `MODE_OR` (1): `a | b`.
- `MODE_XNOR` (2): `!(a ^ b)`.
- `MODE_IMPL` (3): `a |-> ##DELAY b`.

Evaluation:
- Sampling: values are those registered at the edge, i.e. values present before the edge. A value driven by the bench immediately after edge k is first seen at edge k+1.
- Modes 0–2: at edge k with `en`=1, evaluate the expression. The result appears on `pass_o` or `fail_o` for exactly one cycle after edge k.
- Mode 3, antecedent false: at edge k with `en`=1 and `a`=0, `vacuous_o` pulses after edge k. No counter changes.
- Mode 3, antecedent true: at edge k with `en`=1 and `a`=1, push a pending attempt into a DELAY-deep shift register.
- Mode 3, resolution: at edge k+DELAY the attempt resolves on sampled `b`, giving `pass_o` or `fail_o`.
- Mode 3, overlap: overlapping attempts are independent, one per edge, so at most one resolves per edge.
- Mode 3, simultaneous vacuous and resolution: `vacuous_o` and a resolution pulse may assert in the same cycle.
- Timestamp and counters on fail: `fail_ts` loads the attempt start cycle. That is `cycle_cnt` at the evaluating edge for modes 0–2, and `cycle_cnt − DELAY` (mod 2^TS_W) for mode 3. `fail_cnt` increments.
- Counters on pass: `pass_cnt` increments on `pass_o`. Both counters saturate at all-ones.
- `en`=0: no new attempt starts. In-flight mode-3 attempts still resolve.
- `mode` change: a value differing from the previous edge's value clears all pending mode-3 attempts with no report. The new mode evaluates from that same edge.
- `cycle_cnt`: increments every edge regardless of `en`. It wraps at 2^TS_W to 0, and timestamp subtraction wraps likewise.

## Timing
- Reset (`rst`=1 at an edge): `pass_o`, `fail_o` and `vacuous_o` are 0. `fail_ts`, `pass_cnt`, `fail_cnt` and `cycle_cnt` are 0. The pending shift register is cleared, and the stored previous mode becomes `MODE_AND`.
- Edge-0 convention: the first edge with `rst`=0 is cycle 0.
- Latency, modes 0–2: 1 edge from sample to pulse.
- Latency, mode 3: DELAY edges from antecedent to result pulse; the pulse is visible after edge k+DELAY.
- Reset mid-attempt: all pending attempts are discarded silently, and no pulse appears in the cycle after the reset edge.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `sva_mon_pkg` holds:
  - `typedef enum logic [1:0] mode_e` with `MODE_AND`, `MODE_OR`, `MODE_XNOR`, `MODE_IMPL`;
  - `DELAY_MAX` = 15.
- Sub-module `sva_impl_tracker`: the DELAY-deep pending-attempt shift register with flush and resolution logic. It outputs `resolve_valid` and `resolve_pass`.
- The top level holds the sample registers, expression evaluation, counters, timestamp and output registers.

## Test plan
- **MODE_AND:** drive (a,b) = 00, 01, 11, 10 on successive edges 0–3. Require `fail_o` after edges 0, 1, 3 and `pass_o` after edge 2. End state: `fail_cnt`=3, `pass_cnt`=1, `fail_ts`=3.
- **MODE_OR and MODE_XNOR:** drive the same sequence (00, 01, 11, 10).
  - MODE_OR: `fail_o` only after edge 0.
  - MODE_XNOR: fails after edges 1 and 3.
  - Value driven just after an edge: a value driven 1 ps after edge k is evaluated at edge k+1, not k.
- **MODE_IMPL, DELAY=2:**
  - Drive `a`=1 at edge 5 and `b`=1 at edge 7: require `pass_o` after edge 7.
  - Drive `a`=1 at edge 6 and `b`=0 at edge 8: require `fail_o` and `fail_ts`=6.
  - Every edge with `a`=0 gives a `vacuous_o` pulse.
- **Flush and enable:**
  - Start a mode-3 attempt, then switch `mode` to 0 one edge later: no mode-3 result is reported.
  - `en`=0 for 4 edges: no pulses for new attempts, while `cycle_cnt` still advances by 4.
- **Reset and saturation:**
  - Assert `rst` with a pending attempt: all outputs are 0 on the next cycle and there is no late pulse.
  - With `CNT_W`=2, run 6 failing edges: `fail_cnt` holds at 3.
  - With `TS_W`=4, run 20 edges: `cycle_cnt` wraps to 4.
